// File: rtl/led_rate_pkg.sv
// Shared types and default constants for the LED blink-rate decoder.
package led_rate_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int unsigned DEF_HALF_BASE = 32'd4;
    localparam int unsigned DEF_TOL_SHIFT = 32'd2;
    localparam int unsigned DEF_TIMEOUT   = 32'd128;

    // Nominal half-period in clocks for rate code k.
    function automatic int unsigned nominal_half(input int unsigned base, input logic [1:0] k);
        return base << k;
    endfunction

endpackage

// File: rtl/led_rate_decoder_sync_edge_det.sv
// Two-flop synchronizer for the asynchronous LED input plus a delay stage;
// toggle pulses for one clock on every rising or falling edge.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic toggle
);

    logic s1_r;
    logic s_r;
    logic d_r;

    // Synchronize din and keep the previous synchronized value for comparison
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_r <= 1'b0;
            s_r  <= 1'b0;
            d_r  <= 1'b0;
        end else begin
            s1_r <= din;
            s_r  <= s1_r;
            d_r  <= s_r;
        end
    end

    assign toggle = s_r ^ d_r;

endmodule

// File: rtl/led_rate_decoder.sv
// Recovers the 2-bit rate code of a blinking LED by timing its half-periods,
// and flags an LED that has stopped toggling.
module led_rate_decoder
    import led_rate_pkg::*;
#(
    parameter int unsigned HALF_BASE = DEF_HALF_BASE,
    parameter int unsigned TOL_SHIFT = DEF_TOL_SHIFT,
    parameter int unsigned CW        = 16,
    parameter int unsigned LOCK_CNT  = 2,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          led_in,
    output logic [1:0]    rate_code,
    output logic          rate_valid,
    output logic          stuck,
    output logic [CW-1:0] meas_half
);

    localparam logic [2:0]    LOCK_N    = 3'(LOCK_CNT);
    localparam logic [CW-1:0] TIMEOUT_N = CW'(TIMEOUT);
    localparam logic [CW-1:0] HP_MAX    = {CW{1'b1}};

    logic          edge_s;
    logic [CW-1:0] hp_cnt_r;
    logic [CW:0]   hp_ext_s;
    logic [3:0]    win_s;
    logic          hit_s;
    logic [1:0]    hit_code_s;
    logic          timeout_s;

    state_t        state_r, state_nx;
    logic [1:0]    cand_r, cand_nx;
    logic [2:0]    match_r, match_nx;
    logic [1:0]    code_r, code_nx;
    logic          valid_r, valid_nx;
    logic          stuck_r, stuck_nx;
    logic [CW-1:0] meas_r, meas_nx;

    sync_edge_det u_sync (
        .clk    (clk),
        .rst    (rst),
        .din    (led_in),
        .toggle (edge_s)
    );

    // Half-period counter: restarts at 1 on each edge so it reads H on the next edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            hp_cnt_r <= {CW{1'b0}};
        end else if (edge_s) begin
            hp_cnt_r <= CW'(1);
        end else if (hp_cnt_r != HP_MAX) begin
            hp_cnt_r <= hp_cnt_r + CW'(1);
        end else begin
            hp_cnt_r <= hp_cnt_r;
        end
    end

    assign hp_ext_s  = {1'b0, hp_cnt_r};
    assign timeout_s = (hp_cnt_r == TIMEOUT_N);

    // Window test |H - N_k| <= tol_k, rearranged with one spare bit to avoid underflow
    always_comb begin
        logic [CW:0] nom_v;
        logic [CW:0] tol_v;
        win_s = 4'b0000;
        nom_v = {(CW+1){1'b0}};
        tol_v = {(CW+1){1'b0}};
        for (int k = 0; k < 4; k++) begin
            nom_v    = (CW+1)'(nominal_half(HALF_BASE, 2'(k)));
            tol_v    = nom_v >> TOL_SHIFT;
            win_s[k] = ((hp_ext_s + tol_v) >= nom_v) && (hp_ext_s <= (nom_v + tol_v));
        end
    end

    // Windows never overlap, so a valid hit is exactly one-hot
    always_comb begin
        hit_s      = 1'b1;
        hit_code_s = 2'd0;
        case (win_s)
            4'b0001: hit_code_s = 2'd0;
            4'b0010: hit_code_s = 2'd1;
            4'b0100: hit_code_s = 2'd2;
            4'b1000: hit_code_s = 2'd3;
            default: begin
                hit_s      = 1'b0;
                hit_code_s = 2'd0;
            end
        endcase
    end

    // Lock state machine: next state and next register values
    always_comb begin
        state_nx = state_r;
        cand_nx  = cand_r;
        match_nx = match_r;
        code_nx  = code_r;
        valid_nx = valid_r;
        stuck_nx = stuck_r;
        meas_nx  = meas_r;
        case (state_r)
            IDLE: begin
                // First edge only provides the timing reference
                if (edge_s) begin
                    state_nx = MEASURE;
                    stuck_nx = 1'b0;
                end else begin
                    state_nx = IDLE;
                end
            end
            MEASURE: begin
                if (edge_s) begin
                    meas_nx = hp_cnt_r;
                    if (!hit_s) begin
                        match_nx = 3'd0;
                    end else if ((hit_code_s == cand_r) && (match_r != 3'd0)) begin
                        match_nx = match_r + 3'd1;
                    end else begin
                        cand_nx  = hit_code_s;
                        match_nx = 3'd1;
                    end
                    if (hit_s && (match_nx == LOCK_N)) begin
                        state_nx = LOCKED;
                        code_nx  = cand_nx;
                        valid_nx = 1'b1;
                    end else begin
                        state_nx = MEASURE;
                    end
                end else if (timeout_s) begin
                    state_nx = IDLE;
                    stuck_nx = 1'b1;
                    valid_nx = 1'b0;
                    match_nx = 3'd0;
                end else begin
                    state_nx = MEASURE;
                end
            end
            LOCKED: begin
                if (edge_s) begin
                    meas_nx = hp_cnt_r;
                    if (hit_s && (hit_code_s == cand_r)) begin
                        state_nx = LOCKED;
                    end else if (hit_s) begin
                        state_nx = MEASURE;
                        valid_nx = 1'b0;
                        cand_nx  = hit_code_s;
                        match_nx = 3'd1;
                    end else begin
                        state_nx = MEASURE;
                        valid_nx = 1'b0;
                        match_nx = 3'd0;
                    end
                end else if (timeout_s) begin
                    state_nx = IDLE;
                    stuck_nx = 1'b1;
                    valid_nx = 1'b0;
                    match_nx = 3'd0;
                end else begin
                    state_nx = LOCKED;
                end
            end
            default: begin
                state_nx = IDLE;
                valid_nx = 1'b0;
                match_nx = 3'd0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            cand_r  <= 2'd0;
            match_r <= 3'd0;
            code_r  <= 2'd0;
            valid_r <= 1'b0;
            stuck_r <= 1'b0;
            meas_r  <= {CW{1'b0}};
        end else begin
            state_r <= state_nx;
            cand_r  <= cand_nx;
            match_r <= match_nx;
            code_r  <= code_nx;
            valid_r <= valid_nx;
            stuck_r <= stuck_nx;
            meas_r  <= meas_nx;
        end
    end

    assign rate_code  = code_r;
    assign rate_valid = valid_r;
    assign stuck      = stuck_r;
    assign meas_half  = meas_r;

endmodule

// File: tb/tb_led_rate_decoder.sv
// Randomized self-checking bench for led_rate_decoder with a timestamp-based reference model.
module tb_led_rate_decoder;
    import led_rate_pkg::*;

    localparam int CW   = 16;
    localparam int LOCK = 2;
    localparam int TMO  = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          led_in = 1'b0;
    logic [1:0]    rate_code;
    logic          rate_valid;
    logic          stuck;
    logic [CW-1:0] meas_half;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_rate_decoder #(
        .HALF_BASE (DEF_HALF_BASE),
        .TOL_SHIFT (DEF_TOL_SHIFT),
        .CW        (CW),
        .LOCK_CNT  (LOCK),
        .TIMEOUT   (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .led_in     (led_in),
        .rate_code  (rate_code),
        .rate_valid (rate_valid),
        .stuck      (stuck),
        .meas_half  (meas_half)
    );

    // Reference model: per-cycle input history and edge timestamps
    int hist [0:65535];
    int cyc = 3;
    int m_last = 0;
    bit m_primed = 1'b0;
    bit m_locked = 1'b0;
    int m_cand = 0;
    int m_cnt = 0;
    int m_code = 0;
    bit m_valid = 1'b0;
    bit m_stuck = 1'b0;
    int m_meas = 0;

    function automatic int classify(input int h);
        int n, tol, diff;
        for (int k = 0; k < 4; k++) begin
            n    = int'(DEF_HALF_BASE) << k;
            tol  = n >> DEF_TOL_SHIFT;
            diff = (h > n) ? (h - n) : (n - h);
            if (diff <= tol) return k;
        end
        return -1;
    endfunction

    task automatic model_update(input logic r);
        int h, k;
        bit e;
        cyc++;
        if (!r) begin
            hist[cyc] = 0; hist[cyc-1] = 0; hist[cyc-2] = 0;
            m_last = cyc + 1; m_primed = 1'b0; m_locked = 1'b0;
            m_cand = 0; m_cnt = 0; m_code = 0;
            m_valid = 1'b0; m_stuck = 1'b0; m_meas = 0;
        end else begin
            hist[cyc] = int'(led_in);
            e = (hist[cyc-2] != hist[cyc-3]);
            if (e) begin
                h = cyc - m_last;
                m_last = cyc;
                if (!m_primed) begin
                    m_primed = 1'b1;
                    m_stuck  = 1'b0;
                end else begin
                    m_meas = h;
                    k = classify(h);
                    if (m_locked) begin
                        if (k != m_cand) begin
                            m_locked = 1'b0;
                            m_valid  = 1'b0;
                            if (k >= 0) begin m_cand = k; m_cnt = 1; end
                            else m_cnt = 0;
                        end
                    end else begin
                        if (k < 0) m_cnt = 0;
                        else if (k == m_cand && m_cnt > 0) m_cnt++;
                        else begin m_cand = k; m_cnt = 1; end
                        if (k >= 0 && m_cnt == LOCK) begin
                            m_locked = 1'b1; m_code = m_cand; m_valid = 1'b1;
                        end
                    end
                end
            end else if (m_primed && (cyc - m_last) == TMO) begin
                m_primed = 1'b0; m_locked = 1'b0; m_stuck = 1'b1;
                m_valid = 1'b0; m_cnt = 0;
            end
        end
    endtask

    // One clock: drive inputs, advance DUT and model, settle past the edge
    task automatic tick(input logic v, input logic r);
        led_in = v;
        rst    = r;
        @(posedge clk);
        model_update(r);
        #1;
    endtask

    task automatic half(input int h);
        logic nv;
        nv = ~led_in;
        for (int i = 0; i < h; i++) tick(nv, 1'b1);
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0);
        checks++;
        if ({rate_code, rate_valid, stuck, meas_half} !== {2'b00, 1'b0, 1'b0, 16'd0} || dut.state_r !== IDLE) begin
            errors++; $display("FAIL reset_cyc1: got code=%0d valid=%0b stuck=%0b meas=%0d state=%0d, want all 0", rate_code, rate_valid, stuck, meas_half, dut.state_r);
        end
        tick(1'b0, 1'b0);
        checks++;
        if ({rate_code, rate_valid, stuck, meas_half} !== {2'b00, 1'b0, 1'b0, 16'd0} || dut.state_r !== IDLE) begin
            errors++; $display("FAIL reset_cyc2: got code=%0d valid=%0b stuck=%0b meas=%0d state=%0d, want all 0", rate_code, rate_valid, stuck, meas_half, dut.state_r);
        end
    endtask

    task automatic test_rates();
        int hs [4] = '{8, 4, 16, 32};
        logic [1:0] cs [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0);
            half(hs[i]); half(hs[i]);
            checks++;
            if (rate_valid !== 1'b0) begin
                errors++; $display("FAIL rate_prelock h=%0d: valid=%0b want 0", hs[i], rate_valid);
            end
            half(hs[i]);
            checks++;
            if (rate_valid !== 1'b1 || rate_code !== cs[i] || meas_half !== 16'(hs[i])) begin
                errors++; $display("FAIL rate_lock h=%0d: valid=%0b code=%0d meas=%0d want 1/%0d/%0d", hs[i], rate_valid, rate_code, meas_half, cs[i], hs[i]);
            end
        end
    endtask

    task automatic test_switch();
        tick(1'b0, 1'b0);
        half(16); half(16); half(16);
        half(4);
        checks++;
        if (rate_valid !== 1'b1 || rate_code !== 2'b10 || meas_half !== 16'd16) begin
            errors++; $display("FAIL switch_hold: valid=%0b code=%0d meas=%0d want 1/2/16", rate_valid, rate_code, meas_half);
        end
        half(4);
        checks++;
        if (rate_valid !== 1'b0 || rate_code !== 2'b10 || meas_half !== 16'd4) begin
            errors++; $display("FAIL switch_drop: valid=%0b code=%0d meas=%0d want 0/2/4", rate_valid, rate_code, meas_half);
        end
        half(4);
        checks++;
        if (rate_valid !== 1'b1 || rate_code !== 2'b00) begin
            errors++; $display("FAIL switch_relock: valid=%0b code=%0d want 1/0", rate_valid, rate_code);
        end
    endtask

    task automatic test_nomatch();
        int vals [10] = '{5, 6, 20, 24, 3, 40, 2, 41, 10, 12};
        int exps [10] = '{0, 1, 2, 3, 0, 3, -1, -1, 1, 2};
        int j, t;
        logic [1:0] ec;
        int odd [2] = '{11, 22};
        for (int o = 0; o < 2; o++) begin
            tick(1'b0, 1'b0);
            for (int n = 0; n < 5; n++) half(odd[o]);
            checks++;
            if (rate_valid !== 1'b0 || meas_half !== 16'(odd[o])) begin
                errors++; $display("FAIL nomatch h=%0d: valid=%0b meas=%0d want 0/%0d", odd[o], rate_valid, meas_half, odd[o]);
            end
        end
        for (int i = 9; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = vals[i]; vals[i] = vals[j]; vals[j] = t;
            t = exps[i]; exps[i] = exps[j]; exps[j] = t;
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0);
            half(vals[i]); half(vals[i]); half(vals[i]);
            ec = exps[i][1:0];
            checks++;
            if (exps[i] >= 0) begin
                if (rate_valid !== 1'b1 || rate_code !== ec || meas_half !== 16'(vals[i])) begin
                    errors++; $display("FAIL boundary h=%0d: valid=%0b code=%0d meas=%0d want 1/%0d", vals[i], rate_valid, rate_code, meas_half, exps[i]);
                end
            end else begin
                if (rate_valid !== 1'b0 || meas_half !== 16'(vals[i])) begin
                    errors++; $display("FAIL boundary h=%0d: valid=%0b meas=%0d want 0 (no window)", vals[i], rate_valid, meas_half);
                end
            end
        end
    endtask

    task automatic test_stuck();
        int hl;
        tick(1'b0, 1'b0);
        hl = 0;
        for (int r = 0; r < 3; r++) begin
            hl = $urandom_range(10, 6);
            half(hl);
        end
        for (int i = hl; i < 130; i++) tick(led_in, 1'b1);
        checks++;
        if (stuck !== 1'b0 || rate_valid !== 1'b1) begin
            errors++; $display("FAIL stuck_early: stuck=%0b valid=%0b want 0/1", stuck, rate_valid);
        end
        tick(led_in, 1'b1);
        checks++;
        if (stuck !== 1'b1 || rate_valid !== 1'b0 || rate_code !== 2'b01) begin
            errors++; $display("FAIL stuck_set: stuck=%0b valid=%0b code=%0d want 1/0/1", stuck, rate_valid, rate_code);
        end
        for (int i = 0; i < 5; i++) tick(led_in, 1'b1);
        checks++;
        if (stuck !== 1'b1) begin
            errors++; $display("FAIL stuck_hold: stuck=%0b want 1", stuck);
        end
        half(8);
        checks++;
        if (stuck !== 1'b0 || rate_valid !== 1'b0) begin
            errors++; $display("FAIL stuck_clear: stuck=%0b valid=%0b want 0/0", stuck, rate_valid);
        end
        half(8);
        checks++;
        if (rate_valid !== 1'b0) begin
            errors++; $display("FAIL stuck_relock_early: valid=%0b want 0", rate_valid);
        end
        half(8);
        checks++;
        if (rate_valid !== 1'b1 || rate_code !== 2'b01) begin
            errors++; $display("FAIL stuck_relock: valid=%0b code=%0d want 1/1", rate_valid, rate_code);
        end
        half(TMO);
        half(8);
        checks++;
        if (stuck !== 1'b0 || rate_valid !== 1'b0 || meas_half !== 16'(TMO)) begin
            errors++; $display("FAIL edge_vs_timeout: stuck=%0b valid=%0b meas=%0d want 0/0/%0d", stuck, rate_valid, meas_half, TMO);
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 1'b0);
        half(16); half(16); half(16); half(16);
        checks++;
        if (rate_valid !== 1'b1 || rate_code !== 2'b10) begin
            errors++; $display("FAIL midreset_prelock: valid=%0b code=%0d want 1/2", rate_valid, rate_code);
        end
        tick(1'b0, 1'b0);
        checks++;
        if ({rate_code, rate_valid, stuck, meas_half} !== {2'b00, 1'b0, 1'b0, 16'd0} || dut.state_r !== IDLE) begin
            errors++; $display("FAIL midreset_clear: code=%0d valid=%0b stuck=%0b meas=%0d want all 0", rate_code, rate_valid, stuck, meas_half);
        end
        half(16); half(16);
        checks++;
        if (rate_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_early: valid=%0b want 0", rate_valid);
        end
        half(16);
        checks++;
        if (rate_valid !== 1'b1 || rate_code !== 2'b10) begin
            errors++; $display("FAIL midreset_relock: valid=%0b code=%0d want 1/2", rate_valid, rate_code);
        end
    endtask

    task automatic test_random();
        tick(1'b0, 1'b0);
        for (int seg = 0; seg < 150; seg++) begin
            int k, n, tol, runs, h;
            logic nv;
            k    = $urandom_range(3, 0);
            n    = int'(DEF_HALF_BASE) << k;
            tol  = n >> DEF_TOL_SHIFT;
            runs = $urandom_range(5, 1);
            for (int r = 0; r < runs; r++) begin
                h = $urandom_range(n + tol, n - tol);
                if ($urandom_range(9, 0) == 0) h = $urandom_range(60, 1);
                if ($urandom_range(39, 0) == 0) h = $urandom_range(140, 120);
                nv = ~led_in;
                for (int i = 0; i < h; i++) begin
                    tick(nv, 1'b1);
                    checks++;
                    if (rate_code !== m_code[1:0] || rate_valid !== m_valid || stuck !== m_stuck || meas_half !== 16'(m_meas)) begin
                        errors++;
                        $display("FAIL random cyc=%0d: got code=%0d valid=%0b stuck=%0b meas=%0d want code=%0d valid=%0b stuck=%0b meas=%0d",
                                 cyc, rate_code, rate_valid, stuck, meas_half, m_code, m_valid, m_stuck, m_meas);
                    end
                end
            end
            if ($urandom_range(49, 0) == 0) begin
                tick(led_in, 1'b0);
                checks++;
                if (rate_code !== 2'b00 || rate_valid !== 1'b0 || stuck !== 1'b0 || meas_half !== 16'd0) begin
                    errors++; $display("FAIL random_reset: code=%0d valid=%0b stuck=%0b meas=%0d want all 0", rate_code, rate_valid, stuck, meas_half);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rates();
        test_switch();
        test_nomatch();
        test_stuck();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_rate_decoder.md
Name: led_rate_decoder

Overview:
- Receive-side counterpart of the switch-selected LED blink divider.
- Observes a blinking square wave and recovers the 2-bit rate code (switch setting) that produced it, by measuring half-periods.
- Sits on the bench or board loopback path so a blink output can be checked against its switch setting automatically.
- Also flags a stuck (non-toggling) LED.

Parameters:
- HALF_BASE, 4: nominal half-period, in clocks, for code 0. Nominal half-period for code k is N_k = HALF_BASE << k.
- TOL_SHIFT, 2: tolerance for code k is tol_k = N_k >> TOL_SHIFT. Windows must not overlap.
- CW, 16: width of the half-period counter and of meas_half.
- LOCK_CNT, 2: number of consecutive matching half-periods required to assert rate_valid. Range 1..7.
- TIMEOUT, 128: clocks without an edge before stuck asserts. Must exceed N_3 + tol_3 and be less than 2^CW - 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- led_in  in  1  asynchronous blink input.
- rate_code  out  2  recovered rate code.
- rate_valid  out  1  rate_code is locked and valid.
- stuck  out  1  no edge seen for TIMEOUT clocks.
- meas_half  out  CW  last measured half-period, in clocks.

Behaviour:
- Reset: when rst=0 at a clock edge, the following are cleared:
  - Sync flops cleared to 0.
  - hp_cnt=0, state=IDLE, cand_code=0, match_cnt=0.
  - rate_code=0, rate_valid=0, stuck=0, meas_half=0.
  - Reset asserted mid-operation aborts any measurement or lock at that edge.
- Synchronizer and edge detect:
  - Two-flop synchronizer s1 -> s, plus delay flop d.
  - edge = s XOR d; both rising and falling edges count.
- Half-period counter:
  - On an edge cycle, hp_cnt <= 1.
  - Otherwise hp_cnt <= hp_cnt + 1, saturating at 2^CW - 1.
  - A square wave with half-period H clocks therefore yields hp_cnt == H on each edge cycle.
- Classification (combinational, on the edge cycle): code k matches H if |H - N_k| <= tol_k. At most one k can match.
- With defaults, the match windows are:
  - code 0: 3..5
  - code 1: 6..10
  - code 2: 12..20
  - code 3: 24..40
  - any other value: no match.
- All outputs are registered and update on the clock edge that ends the edge-detect cycle. Latency from an led_in transition (first sampling edge) to the output update is 3 clocks.
- State machine, IDLE:
  - An edge moves to MEASURE and clears stuck.
  - No measurement is taken, because the first edge has no reference.
- State machine, MEASURE, on each edge:
  - meas_half <= H.
  - If the match equals cand_code and match_cnt > 0: match_cnt++.
  - If the match differs from cand_code: cand_code <= k and match_cnt <= 1.
  - If nothing matches: match_cnt <= 0.
  - When match_cnt reaches LOCK_CNT, go to LOCKED and set rate_code <= cand_code and rate_valid <= 1 in the same update.
  - With LOCK_CNT=1, a single match locks.
- State machine, LOCKED, on each edge:
  - meas_half <= H.
  - If the same code matches, stay locked.
  - If a different code matches: rate_valid <= 0, cand_code <= k, match_cnt <= 1, go to MEASURE.
  - If nothing matches: rate_valid <= 0, match_cnt <= 0, go to MEASURE.
  - rate_code holds its last locked value while rate_valid=0.
- Timeout:
  - Applies in MEASURE or LOCKED when hp_cnt == TIMEOUT with no edge that cycle.
  - Go to IDLE with stuck <= 1, rate_valid <= 0, match_cnt <= 0.
  - Timeout is not checked in IDLE, and stuck stays high until the next edge.
- Simultaneous edge and timeout threshold: the edge wins and is measured normally (H = TIMEOUT gives no match).
- A glitch shorter than 1 clock may be missed. That is acceptable.

Decomposition:
- Package led_rate_pkg holds:
  - State enum: IDLE, MEASURE, LOCKED.
  - Default constants: HALF_BASE, TOL_SHIFT, TIMEOUT.
  - Function nominal_half(k).
- One sub-module, sync_edge_det: two-flop synchronizer, delay flop, edge output, synchronous active-low reset to 0.

Test Plan:
- Reset with rst=0 for 2 clocks, led_in toggling -> all outputs 0 and state IDLE for the whole reset period.
- Square wave with half-period 8 -> after the 1st edge plus 2 measured edges, rate_valid=1, rate_code=01, meas_half=8. Repeat for half-periods 4, 16, 32 -> codes 00, 10, 11.
- Lock at half-period 16, then switch to 4 -> first 4-clock measurement drops rate_valid, rate_code stays 10; after the next matching edge, rate_valid=1, rate_code=00.
- Half-periods 11 and 22 (no window) -> rate_valid stays 0 and meas_half shows 11/22. Edge values 5, 6, 20, 24 classify as 00, 01, 10, 11.
- Lock on code 01, then hold led_in constant -> stuck=1 and rate_valid=0 once hp_cnt hits 128. Resume toggling -> stuck=0 on the first edge and relock after LOCK_CNT matches.
- Drop rst for 1 clock while LOCKED -> all outputs 0 next cycle; relock requires a fresh first edge plus 2 matches.
